// File: rtl/logic_unit_arbiter_if.sv
// Bundle between the logic-unit arbiter and its neighbours: two command ports,
// the shared logic-unit pins and the registered response port.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]            req_valid;
  logic [1:0][1:0]       req_fun;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0]            req_ready;

  logic                  lu_en;
  logic [1:0]            lu_fun;
  logic [WIDTH-1:0]      lu_in1;
  logic [WIDTH-1:0]      lu_in2;
  logic [WIDTH-1:0]      lu_out;
  logic                  lu_flag;

  logic                  rsp_valid;
  logic                  rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  rsp_ready;

  // slave: the arbiter itself
  modport slave (
    input  req_valid, req_fun, req_a, req_b, lu_out, lu_flag, rsp_ready,
    output req_ready, lu_en, lu_fun, lu_in1, lu_in2,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // master: requesters, logic unit and response consumer
  modport master (
    output req_valid, req_fun, req_a, req_b, lu_out, lu_flag, rsp_ready,
    input  req_ready, lu_en, lu_fun, lu_in1, lu_in2,
           rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin sequencer sharing one combinational logic unit between two
// requesters; one op in flight, result held in a backpressured response reg.
module logic_unit_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] op_count_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           fun_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 id_q, last_id_q;
  logic                 rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [WIDTH-1:0]     rsp_data_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 grant, hs, lu_en, rsp_fire;
  logic [1:0]           ready;

  // On a tie the requester that did not win last time gets the slot.
  always_comb grant = (bus.req_valid == 2'b11) ? ~last_id_q : bus.req_valid[1];

  for (genvar i = 0; i < 2; i++) begin : g_rdy
    assign ready[i] = (state_q == IDLE) & bus.req_valid[i] & (grant == (i == 1));
  end

  assign hs       = |ready;
  assign rsp_fire = (state_q == RESP) & bus.rsp_ready;
  assign cnt_d    = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lu_en   = 1'b0;
    unique case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE: begin
        lu_en   = 1'b1;
        state_d = RESP;
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fun_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        fun_q     <= bus.req_fun[grant];
        a_q       <= bus.req_a[grant];
        b_q       <= bus.req_b[grant];
        id_q      <= grant;
        last_id_q <= grant;
      end
      if (state_q == ISSUE) begin
        rsp_data_q  <= bus.lu_out;
        rsp_err_q   <= ~bus.lu_flag;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
        cnt_q       <= cnt_d;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.lu_en     = lu_en;
  assign bus.lu_fun    = fun_q;
  assign bus.lu_in1    = a_q;
  assign bus.lu_in2    = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy_o        = (state_q != IDLE);
  assign op_count_o    = cnt_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table of single ops plus
// hand-written tie/fairness, backpressure and mid-op reset sequences.
module tb_logic_unit_arbiter;
  localparam int W = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [CW-1:0] op_count;
  logic          flag_bad;
  logic [W-1:0]  lu_r;
  int            ntests = 0;
  int            nfail  = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(W)) bus ();

  logic_unit_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy),
    .op_count_o (op_count)
  );

  // Logic unit stand-in; flag_bad forces an invalid flag during issue.
  always_comb begin
    lu_r = '0;
    case (bus.lu_fun)
      2'b00: lu_r = bus.lu_in1 & bus.lu_in2;
      2'b01: lu_r = bus.lu_in1 | bus.lu_in2;
      2'b10: lu_r = ~(bus.lu_in1 & bus.lu_in2);
      2'b11: lu_r = ~(bus.lu_in1 | bus.lu_in2);
      default: lu_r = '0;
    endcase
    bus.lu_out  = bus.lu_en ? lu_r : '0;
    bus.lu_flag = bus.lu_en & ~flag_bad;
  end

  typedef struct {
    logic         id;
    logic [1:0]   fun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bad;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input vec_t v);
    int w;
    @(posedge clk); #1;
    bus.req_valid[v.id] = 1'b1;
    bus.req_fun[v.id]   = v.fun;
    bus.req_a[v.id]     = v.a;
    bus.req_b[v.id]     = v.b;
    flag_bad            = v.bad;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready[v.id] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", bus.req_ready[v.id], 1);
    chk("lu_en_idle", bus.lu_en, 0);
    @(posedge clk); #1;
    bus.req_valid[v.id] = 1'b0;
    @(negedge clk);
    chk("lu_en_issue", bus.lu_en, 1);
    chk("lu_fun", bus.lu_fun, v.fun);
    chk("lu_in1", bus.lu_in1, v.a);
    chk("lu_in2", bus.lu_in2, v.b);
    @(negedge clk);
    chk("lu_en_resp", bus.lu_en, 0);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_data", bus.rsp_data, v.exp);
    chk("rsp_id", bus.rsp_id, v.id);
    chk("rsp_err", bus.rsp_err, v.bad);
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk("rsp_valid_done", bus.rsp_valid, 0);
    chk("op_count", op_count, exp_cnt);
    flag_bad = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic         ids[4];
    logic [W-1:0] dat[4];
    int           cyc[4];
    int           n;

    vecs[0] = '{1'b0, 2'b00, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000};
    vecs[1] = '{1'b1, 2'b01, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0};
    vecs[2] = '{1'b0, 2'b10, 16'hFFFF, 16'h00FF, 1'b0, 16'hFF00};
    vecs[3] = '{1'b1, 2'b11, 16'h0000, 16'h0001, 1'b0, 16'hFFFE};
    vecs[4] = '{1'b0, 2'b00, 16'h1234, 16'hFFFF, 1'b1, 16'h1234};
    vecs[5] = '{1'b1, 2'b01, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF};

    rst           = 1'b1;
    flag_bad      = 1'b0;
    bus.req_valid = '0;
    bus.req_fun   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    exp_cnt       = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_lu_en", bus.lu_en, 0);
    chk("rst_lu_in1", bus.lu_in1, 0);
    chk("rst_op_count", op_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // Tie after reset: req0 first, then strict alternation every 3 cycles.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_cnt = '0;
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.req_fun[0] = 2'b01; bus.req_a[0] = 16'h00F0; bus.req_b[0] = 16'h0F00;
    bus.req_fun[1] = 2'b11; bus.req_a[1] = 16'h0000; bus.req_b[1] = 16'h0001;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      chk("ready_exclusive", bus.req_ready[0] & bus.req_ready[1], 0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids[n] = bus.rsp_id;
        dat[n] = bus.rsp_data;
        cyc[n] = c;
        n++;
        if (n == 4) bus.req_valid = 2'b00;
      end
    end
    chk("fair_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fair_id", ids[i], i % 2);
      chk("fair_data", dat[i], (i % 2) ? 16'hFFFE : 16'h0FF0);
      if (i > 0) chk("fair_interval", cyc[i] - cyc[i-1], 3);
    end
    @(negedge clk);
    chk("fair_idle", busy, 0);
    chk("fair_op_count_wrap", op_count, 0);

    // Backpressure: response held for 5 cycles, req1 waiting meanwhile.
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1;
    bus.req_fun[0] = 2'b00; bus.req_a[0] = 16'hAAAA; bus.req_b[0] = 16'hFFFF;
    @(negedge clk);
    chk("bp_ready0", bus.req_ready[0], 1);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_data", bus.rsp_data, 16'hAAAA);
      chk("bp_rsp_id", bus.rsp_id, 0);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_lu_en", bus.lu_en, 0);
      chk("bp_op_count", op_count, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("bp_done_valid", bus.rsp_valid, 0);
    chk("bp_done_op_count", op_count, 1);

    // Reset during ISSUE; afterwards a tie must go to req0 again.
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("mid_ready1", bus.req_ready[1], 1);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("mid_lu_en", bus.lu_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_lu_en_rst", bus.lu_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_op_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_fun[0] = 2'b00; bus.req_a[0] = 16'hF0F0; bus.req_b[0] = 16'hFF00;
    #1;
    chk("mid_tie_ready0", bus.req_ready[0], 1);
    chk("mid_tie_ready1", bus.req_ready[1], 0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rsp_id", bus.rsp_id, 0);
    chk("mid_rsp_data", bus.rsp_data, 16'hF000);
    @(negedge clk);
    chk("mid_op_count_after", op_count, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Sequencer and arbiter that shares one combinational logic unit (enable, 2-bit function select, two WIDTH operands, result and flag) between two requesters. It accepts a command by valid/ready, drives the unit for exactly one cycle, and captures the result into a registered response port with backpressure. Arbitration is round-robin. A wrapping counter tracks completed operations. Sits between the command sources and the logic unit instance inside the ALU.

Parameters:
WIDTH, 16, operand/result width (matches the logic unit)
CNT_WIDTH, 8, width of completed-operation counter

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
REQ0_VALID  in  1  requester 0 command valid
REQ0_FUN  in  2  requester 0 function (00 AND, 01 OR, 10 NAND, 11 NOR)
REQ0_A  in  WIDTH  requester 0 operand 1
REQ0_B  in  WIDTH  requester 0 operand 2
REQ0_READY  out  1  requester 0 command accepted this cycle
REQ1_VALID, REQ1_FUN, REQ1_A, REQ1_B, REQ1_READY  same as requester 0
LU_EN  out  1  logic unit enable
LU_FUN  out  2  logic unit function select
LU_IN1  out  WIDTH  logic unit operand 1
LU_IN2  out  WIDTH  logic unit operand 2
LU_OUT  in  WIDTH  logic unit result (combinational)
LU_FLAG  in  1  logic unit valid flag
RSP_VALID  out  1  response valid
RSP_ID  out  1  requester that issued the response
RSP_DATA  out  WIDTH  registered result
RSP_ERR  out  1  LU_FLAG was 0 during issue
RSP_READY  in  1  response consumer ready
BUSY  out  1  state != IDLE
OP_COUNT  out  CNT_WIDTH  completed responses, wraps

Behaviour:
- Async reset (RST=1): state IDLE, LAST_ID=1 (req0 wins first tie), command registers 0, RSP_VALID/RSP_ID/RSP_DATA/RSP_ERR=0, OP_COUNT=0. LU_EN=0, BUSY=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: GRANT = only valid requester; if both valid, GRANT = !LAST_ID. REQx_READY = (state==IDLE) & REQx_VALID & (GRANT==x), combinational; never both high. On handshake: latch FUN/A/B and ID, set LAST_ID=GRANT, go to ISSUE. With no valid request, stay in IDLE.
- ISSUE (exactly 1 cycle): LU_EN=1; LU_FUN/LU_IN1/LU_IN2 = latched command. At the clock edge: RSP_DATA<=LU_OUT, RSP_ERR<=~LU_FLAG, RSP_ID<=latched ID, RSP_VALID<=1, go to RESP.
- LU_FUN/LU_IN1/LU_IN2 always drive the latched registers. They are 0 after reset. LU_EN=0 in IDLE and RESP.
- RESP: RSP_VALID=1. RSP_DATA/ID/ERR are held stable until RSP_READY=1. On RSP_VALID&RSP_READY: RSP_VALID<=0, OP_COUNT<=OP_COUNT+1 (mod 2^CNT_WIDTH), go to IDLE. Both REQx_READY are 0.
- Latency: handshake edge at cycle n, RSP_VALID high from cycle n+2. With RSP_READY held high, the minimum issue interval is 3 cycles.
- A requester dropping VALID before its handshake is not an error. It is simply not granted.
- Reset mid-operation (ISSUE or RESP): the in-flight command and response are discarded, and everything returns to reset values immediately. No response is produced.

Test Plan:
- Single op: REQ0 FUN=00 A=F0F0 B=FF00, RSP_READY=1 -> REQ0_READY at cycle n; LU_EN high only at n+1; at n+2 RSP_VALID=1, RSP_DATA=F000, RSP_ID=0, RSP_ERR=0; OP_COUNT=1 next cycle.
- Simultaneous after reset: REQ0 FUN=01 A=00F0 B=0F00, REQ1 FUN=11 A=0000 B=0001 same cycle -> first response ID=0, DATA=0FF0; second response ID=1, DATA=FFFE; REQ1_READY low until REQ0 done.
- Fairness: both valid continuously for 4 ops, RSP_READY=1 -> RSP_ID sequence 0,1,0,1; responses 3 cycles apart; REQ0_READY&REQ1_READY never both 1.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID with DATA=AAAA -> RSP_VALID/DATA/ID stable, both READY=0, BUSY=1, LU_EN=0, OP_COUNT unchanged; completes the cycle RSP_READY=1.
- Reset mid-op: assert RST during ISSUE -> RSP_VALID=0, LU_EN=0, BUSY=0, OP_COUNT=0 asynchronously; after release with both valid, req0 is granted first.
- Wrap/error: CNT_WIDTH=2, 5 ops -> OP_COUNT=1; one op with LU_FLAG forced 0 -> RSP_ERR=1 for that response only.
